nio2_sys_gpio_pio: RTL and testbench
====================================

// Module: nio2_sys_gpio_pio
// PURPOSE
//  Parametrised Avalon-MM GPIO slave; successor to the 8-bit output-only LED PIO.
//  Adds: configurable width, a synchronised input port, and atomic set/clear of the output register.
//  Adds: per-bit edge capture with write-1-to-clear, and a maskable level interrupt to the Nios II IRQ.
//  Connects to the system interconnect as an Avalon-MM slave with read latency 1; the IRQ goes to the CPU.
// PARAMETERS
//  DATA_WIDTH   8    width of out_port/in_port and of every register (1..32)
//  RESET_VALUE  0    out_port value after reset (DATA_WIDTH bits)
//  EDGE_TYPE    0    capture edge: 0 rising, 1 falling, 2 any
//  SYNC_STAGES  2    flops in the in_port synchroniser chain (2..4)
// PORTS
//  clk         in   1           system clock
//  reset_n     in   1           reset, asynchronous, active-low
//  address     in   3           word address
//  chipselect  in   1           slave select
//  read_n      in   1           read strobe, active-low
//  write_n     in   1           write strobe, active-low
//  writedata   in   32          write data; bits above DATA_WIDTH ignored
//  readdata    out  32          read data, valid 1 cycle after read; upper bits zero
//  in_port     in   DATA_WIDTH  asynchronous inputs
//  out_port    out  DATA_WIDTH  output register
//  irq         out  1           level interrupt, active-high
// BEHAVIOUR
//  Reset (async):
//   - out_port = RESET_VALUE; readdata, irq_mask, edge_cap, irq = 0.
//   - All synchroniser flops and prev_in = 0.
//  Write = chipselect & ~write_n. Read = chipselect & ~read_n. Register map:
//   0 DATA_IN   RO   synchronised in_port; writes ignored
//   1 DATA_OUT  RW   out_port <= writedata[DATA_WIDTH-1:0]
//   2 IRQ_MASK  RW   per-bit interrupt enable
//   3 EDGE_CAP  R/W1C  read captured edges; writing 1 clears that bit, writing 0 leaves it unchanged
//   4 OUTSET    WO   out_port <= out_port | wdata; reads 0
//   5 OUTCLEAR  WO   out_port <= out_port & ~wdata; reads 0
//   6,7         reserved; reads 0, writes ignored
//  Write effects:
//   - Registered; visible on out_port the clock edge after the write cycle.
//  Read timing:
//   - readdata registered on the clock edge ending the read cycle.
//   - readdata holds its value until the next read.
//  Input path and edge detection:
//   - in_sync = last stage of the SYNC_STAGES chain; prev_in <= in_sync every cycle.
//   - rise = in_sync & ~prev_in; fall = ~in_sync & prev_in; edge selected per EDGE_TYPE.
//   - An in_port change before edge k shows in DATA_IN from edge k+SYNC_STAGES-1.
//   - The matching EDGE_CAP bit sets at edge k+SYNC_STAGES; irq asserts at edge k+SYNC_STAGES+1.
//   - edge_cap[i] next = (edge_cap[i] & ~clr[i]) | edge[i]; a new edge wins over a same-cycle W1C.
//  Interrupt:
//   - irq registered: irq <= |(edge_cap & irq_mask). Clearing the bit or mask drops irq one cycle later.
//  Simultaneous events:
//   - Only one write per cycle (single address), so OUTSET/OUTCLEAR/DATA_OUT never collide.
//  Known startup behaviour:
//   - prev_in resets to 0, so a pin held high through reset records a rising edge SYNC_STAGES cycles after release.
//   - Software clears EDGE_CAP during init.
//  Reset mid-operation:
//   - Async reset returns every register to its reset value immediately.
//   - A pending read produces readdata 0.
// TESTING
//  T1: reset, DATA_WIDTH=8, RESET_VALUE=8'hA5 -> out_port=A5, irq=0; write 1<-0x3C -> out_port=3C next cycle.
//  T2: OUTSET 0x03 then OUTCLEAR 0x30 from 0x3C -> out_port 0x3F then 0x0F; read 4 and 5 -> 0.
//  T3: in_port 0->0x81, EDGE_TYPE=0 -> DATA_IN=0x81 after 2 clk; EDGE_CAP=0x81 at edge 3; irq stays 0 with mask 0.
//  T4: IRQ_MASK<-0x01 with EDGE_CAP=0x81 -> irq=1 next cycle; W1C 0x01 -> irq=0 one cycle after clear; EDGE_CAP=0x80.
//  T5: W1C bit 0 in the same cycle a new rising edge on bit 0 reaches edge_cap -> bit stays 1, irq stays 1.
//  T6: reset_n low mid-read with out_port=0xFF, edge_cap=0x80 -> all zero/RESET_VALUE at once; readdata=0.

Source files
------------

// File: rtl/nio2_sys_gpio_pio.sv
// nio2_sys_gpio_pio: Avalon-MM GPIO slave with set/clear outputs, synchronised inputs,
// per-bit edge capture (write-1-to-clear) and a maskable level interrupt.
module nio2_sys_gpio_pio #(
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter int                    EDGE_TYPE   = 0,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  read_n,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  irq
);
   logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [DATA_WIDTH-1:0] r_prev, r_out, r_mask, r_cap;
   logic [31:0]           r_readdata;
   logic                  r_irq;
   logic                  w_wr, w_rd, w_unused;
   logic [DATA_WIDTH-1:0] w_wdata, w_in_sync, w_rise, w_fall, w_edge, w_clr, w_out_nxt;
   logic [31:0]           w_rmux;

   assign w_wr      = chipselect & ~write_n;
   assign w_rd      = chipselect & ~read_n;
   assign w_wdata   = writedata[DATA_WIDTH-1:0];
   assign w_unused  = ^writedata;
   assign w_in_sync = r_sync[SYNC_STAGES-1];
   assign w_rise    = w_in_sync & ~r_prev;
   assign w_fall    = ~w_in_sync & r_prev;
   assign w_edge    = (EDGE_TYPE == 0) ? w_rise : (EDGE_TYPE == 1) ? w_fall : (w_rise | w_fall);
   assign w_clr     = (w_wr && address == 3'd3) ? w_wdata : '0;

   always_comb begin
      w_out_nxt = r_out;
      if (w_wr)
         w_out_nxt = (address == 3'd1) ? w_wdata :
                     (address == 3'd4) ? (r_out | w_wdata) :
                     (address == 3'd5) ? (r_out & ~w_wdata) : r_out;
   end

   always_comb begin
      w_rmux = '0;
      case (address)
         3'd0:    w_rmux[DATA_WIDTH-1:0] = w_in_sync;
         3'd1:    w_rmux[DATA_WIDTH-1:0] = r_out;
         3'd2:    w_rmux[DATA_WIDTH-1:0] = r_mask;
         3'd3:    w_rmux[DATA_WIDTH-1:0] = r_cap;
         default: w_rmux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
         r_prev     <= '0;
         r_out      <= RESET_VALUE;
         r_mask     <= '0;
         r_cap      <= '0;
         r_readdata <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_sync[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev <= w_in_sync;
         r_out  <= w_out_nxt;
         if (w_wr && address == 3'd2) r_mask <= w_wdata;
         // a fresh edge overrides a same-cycle clear of that bit
         r_cap  <= (r_cap & ~w_clr) | w_edge;
         if (w_rd) r_readdata <= w_rmux;
         r_irq  <= |(r_cap & r_mask);
      end
   end

   assign readdata = r_readdata;
   assign out_port = r_out;
   assign irq      = r_irq;
endmodule

// File: tb/tb_nio2_sys_gpio_pio.sv
// tb_nio2_sys_gpio_pio: directed and random bus/pin stimulus checked against a
// transaction-level model of the GPIO register file with a pin-delay queue.
module tb_nio2_sys_gpio_pio;
   localparam int S = 2;
   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0, read_n = 1'b1, write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [7:0]  in_port = '0;
   logic [7:0]  out_port;
   logic        irq;
   int          errs = 0, checks = 0;
   logic [7:0]  m_out, m_mask, m_cap;
   logic [31:0] m_rd;
   logic        m_irq;
   logic [7:0]  q[$];

   nio2_sys_gpio_pio #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .out_port(out_port), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_out = 8'hA5; m_mask = '0; m_cap = '0; m_rd = '0; m_irq = 1'b0;
      q.delete();
      for (int i = 0; i <= S; i++) q.push_back(8'h00);
   endtask

   // One clock: predict from the values driven now, wait the edge, compare.
   task automatic step();
      logic [7:0] sync_v, prev_v, edges, wd, clr;
      logic wr, rd;
      sync_v = q[1];
      prev_v = q[0];
      edges  = sync_v & ~prev_v;
      wr = chipselect & ~write_n;
      rd = chipselect & ~read_n;
      wd = writedata[7:0];
      if (rd) m_rd = (address == 0) ? {24'h0, sync_v} : (address == 1) ? {24'h0, m_out} :
                     (address == 2) ? {24'h0, m_mask} : (address == 3) ? {24'h0, m_cap} : 32'h0;
      m_irq = |(m_cap & m_mask);
      clr = (wr && address == 3) ? wd : 8'h00;
      m_cap = (m_cap & ~clr) | edges;
      if (wr && address == 1) m_out = wd;
      if (wr && address == 4) m_out = m_out | wd;
      if (wr && address == 5) m_out = m_out & ~wd;
      if (wr && address == 2) m_mask = wd;
      q.push_back(in_port);
      void'(q.pop_front());
      @(posedge clk);
      #1;
      chk("out_port", {24'h0, out_port}, {24'h0, m_out});
      chk("irq", {31'h0, irq}, {31'h0, m_irq});
      chk("readdata", readdata, m_rd);
   endtask

   task automatic idle();
      chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = a; writedata = d;
      step();
      idle();
   endtask

   task automatic rd(input logic [2:0] a);
      chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; address = a;
      step();
      idle();
   endtask

   initial begin
      model_reset();
      #2 reset_n = 1'b0;
      #10;
      chk("T1 reset out", {24'h0, out_port}, 32'hA5);
      chk("T1 reset irq", {31'h0, irq}, 32'h0);
      chk("T1 reset rd", readdata, 32'h0);
      @(negedge clk) reset_n = 1'b1;
      step();
      // T1/T2: output register, set and clear
      wr(1, 32'hFFFF_FF3C);
      chk("T1 out 3C", {24'h0, out_port}, 32'h3C);
      wr(4, 32'h03);
      chk("T2 outset", {24'h0, out_port}, 32'h3F);
      wr(5, 32'h30);
      chk("T2 outclr", {24'h0, out_port}, 32'h0F);
      rd(4); chk("T2 rd4", readdata, 32'h0);
      rd(1); chk("T2 rd1", readdata, 32'h0F);
      rd(5); chk("T2 rd5", readdata, 32'h0);
      rd(7); chk("rd reserved", readdata, 32'h0);
      // T3: input sync and edge capture, mask 0
      in_port = 8'h81;
      step(); step();
      rd(0); chk("T3 data_in", readdata, 32'h81);
      rd(3); chk("T3 edge_cap", readdata, 32'h81);
      chk("T3 irq", {31'h0, irq}, 32'h0);
      wr(0, 32'hFF);
      step();
      // T4: mask and W1C
      wr(2, 32'h01);
      step(); chk("T4 irq on", {31'h0, irq}, 32'h1);
      wr(3, 32'h01); chk("T4 irq held", {31'h0, irq}, 32'h1);
      step(); chk("T4 irq off", {31'h0, irq}, 32'h0);
      rd(3); chk("T4 cap", readdata, 32'h80);
      // T5: new edge collides with W1C
      in_port = 8'h80;
      repeat (4) step();
      in_port = 8'h81;
      step(); step();
      wr(3, 32'h01);
      step(); chk("T5 irq", {31'h0, irq}, 32'h1);
      rd(3); chk("T5 cap", readdata, 32'h81);
      wr(3, 32'hFF);
      step();
      // random traffic
      for (int n = 0; n < 400; n++) begin
         chipselect = 1'($urandom_range(0, 1));
         read_n = 1'($urandom_range(0, 1));
         write_n = 1'($urandom_range(0, 1));
         address = 3'($urandom_range(0, 7));
         writedata = $urandom;
         if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
         step();
      end
      // T6: async reset during a read
      idle();
      wr(1, 32'hFF);
      chipselect = 1'b1; read_n = 1'b0; address = 3'd1;
      #3 reset_n = 1'b0;
      #1;
      chk("T6 out", {24'h0, out_port}, 32'hA5);
      chk("T6 irq", {31'h0, irq}, 32'h0);
      chk("T6 rd", readdata, 32'h0);
      idle();
      in_port = 8'h00;
      model_reset();
      @(negedge clk) reset_n = 1'b1;
      step();
      rd(3); chk("T6 cap", readdata, 32'h0);
      rd(1); chk("T6 out rd", readdata, 32'hA5);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
